// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module : jk_pkg
// Brief  : Shared definitions for the JK flip-flop library. It holds the bank
//          operating-mode encodings, the {j,k} truth-table encodings and the
//          single-bit next-state function.
// Rev    : 1.0  initial release
// ============================================================================
package jk_pkg;

  // Operating modes of jk_reg_bank
  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;
  localparam logic [1:0] MODE_LD = 2'b11;

  // JK truth-table encodings, indexed as {j,k}
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Next state of one JK cell given its current state and J/K inputs
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      JK_HOLD:   r = q;
      JK_RESET:  r = 1'b0;
      JK_SET:    r = 1'b1;
      default:   r = ~q;      // JK_TOGGLE
    endcase
    return r;
  endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module : jk_cell
// Brief  : One JK flip-flop bit with synchronous active-low reset, clock
//          enable and a synchronous load override.
// Ports  : clk     rising-edge clock
//          rst_n   synchronous active-low reset, loads rst_val
//          rst_val value taken on reset
//          ce      clock enable; 0 holds q
//          ld      load select; when set, q takes ld_d instead of JK action
//          ld_d    load data
//          j, k    JK inputs
//          q       registered state
// Rev    : 1.0  initial release
// ============================================================================
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic ce,
  input  logic ld,
  input  logic ld_d,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  // Priority: reset, then enable, then load, then JK action
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= rst_val;
    end else if (ce) begin
      if (ld) begin
        r_q <= ld_d;
      end else begin
        r_q <= jk_next(r_q, j, k);
      end
    end
  end

  assign q = r_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_reg_bank.sv
`default_nettype none
// ============================================================================
// Module : jk_reg_bank
// Brief  : Bank of WIDTH JK cells with four modes: per-bit JK, up-count,
//          down-count and parallel load. The count modes drive each cell's
//          J/K from a carry (up) or borrow (down) chain, so every bit is a
//          toggle cell enabled when all lower bits are ones (up) or zeros
//          (down).
// Ports  : clk    rising-edge clock
//          rst_n  synchronous active-low reset, q <= RST_VAL
//          en     global enable; 0 holds q in every mode
//          mode   00 JK, 01 up, 10 down, 11 load
//          j, k   per-bit JK inputs (JK mode only)
//          d      load data (load mode only)
//          q      registered state
//          qbar   ~q, derived combinationally
//          tc     terminal count, combinational from q and mode
// Rev    : 1.0  initial release
// ============================================================================
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_up_t;   // bit i toggles when counting up
  logic [WIDTH-1:0] w_dn_t;   // bit i toggles when counting down
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_ld;

  // Carry/borrow chain: each bit's toggle condition is a reduction over the
  // bits below it, so no bit depends on another chain bit combinationally.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    if (i == 0) begin : g_lsb
      assign w_up_t[i] = 1'b1;
      assign w_dn_t[i] = 1'b1;
    end else begin : g_upper
      assign w_up_t[i] = &w_q[i-1:0];
      assign w_dn_t[i] = ~|w_q[i-1:0];
    end
  end

  // Per-bit J/K source selection
  always_comb begin
    w_j = '0;
    w_k = '0;
    case (mode)
      MODE_JK: begin
        w_j = j;
        w_k = k;
      end
      MODE_UP: begin
        w_j = w_up_t;
        w_k = w_up_t;
      end
      MODE_DN: begin
        w_j = w_dn_t;
        w_k = w_dn_t;
      end
      default: begin
        w_j = '0;   // load mode: JK path unused, cells take ld_d
        w_k = '0;
      end
    endcase
  end

  assign w_ld = (mode == MODE_LD);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (RST_VAL[i]),
      .ce      (en),
      .ld      (w_ld),
      .ld_d    (d[i]),
      .j       (w_j[i]),
      .k       (w_k[i]),
      .q       (w_q[i])
    );
  end

  assign q    = w_q;
  assign qbar = ~w_q;

  // Terminal count is independent of en so a consumer can see the wrap
  // condition even while the bank is stalled.
  always_comb begin
    tc = 1'b0;
    case (mode)
      MODE_UP: tc = &w_q;
      MODE_DN: tc = ~|w_q;
      default: tc = 1'b0;
    endcase
  end

endmodule : jk_reg_bank
`default_nettype wire

// File: tb/tb_jk_reg_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_jk_reg_bank
// Brief  : Directed and randomised self-checking bench for jk_reg_bank with
//          WIDTH=4, RST_VAL=4'b1010.
// Rev    : 1.0  initial release
// ============================================================================
module tb_jk_reg_bank;

  localparam int         W      = 4;
  localparam logic [3:0] RV     = 4'b1010;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;

  int n_checks = 0;
  int n_fail   = 0;

  jk_reg_bank #(
    .WIDTH   (W),
    .RST_VAL (RV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .j     (j),
    .k     (k),
    .d     (d),
    .q     (q),
    .qbar  (qbar),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the randomised phase
  logic [3:0] m_q;
  logic [3:0] m_tc;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 2'b01;
    j     = 4'b0000;
    k     = 4'b0000;
    d     = 4'b0000;
    #2;

    // ---------------- Reset ----------------
    step();
    check("rst_q",    q,          4'b1010);
    check("rst_qbar", qbar,       4'b0101);
    check("rst_tc",   {3'b0, tc}, 4'b0000);
    repeat (3) step();
    check("rst_hold_q", q, 4'b1010);

    // ---------------- JK table ----------------
    rst_n = 1'b1;
    mode  = 2'b00;
    j     = 4'b0011;
    k     = 4'b0101;
    #1;
    check("jk_tc", {3'b0, tc}, 4'b0000);
    step();
    // bit0 toggle 0->1, bit1 set, bit2 reset, bit3 holds 1
    check("jk_mixed", q, 4'b1011);
    j = 4'b1111;
    k = 4'b1111;
    step();
    check("jk_toggle", q, 4'b0100);
    check("jk_qbar",   qbar, 4'b1011);

    // ---------------- Up-count wrap ----------------
    mode = 2'b11;
    d    = 4'b1110;
    j    = 4'b0101;   // ignored while loading
    k    = 4'b1010;
    step();
    check("ld_1110", q, 4'b1110);
    mode = 2'b01;
    d    = 4'b0000;   // ignored while counting
    #1;
    check("up_tc_1110", {3'b0, tc}, 4'b0000);
    step();
    check("up_1111",    q,          4'b1111);
    check("up_tc_1111", {3'b0, tc}, 4'b0001);
    step();
    check("up_wrap",    q,          4'b0000);
    check("up_tc_0000", {3'b0, tc}, 4'b0000);
    step();
    check("up_0001", q, 4'b0001);

    // ---------------- Down-count wrap ----------------
    mode = 2'b11;
    d    = 4'b0001;
    step();
    check("ld_0001", q, 4'b0001);
    mode = 2'b10;
    step();
    check("dn_0000",    q,          4'b0000);
    check("dn_tc_0000", {3'b0, tc}, 4'b0001);
    step();
    check("dn_wrap",    q,          4'b1111);
    check("dn_tc_1111", {3'b0, tc}, 4'b0000);
    step();
    check("dn_1110", q, 4'b1110);
    en = 1'b0;
    step();
    check("en0_hold1", q, 4'b1110);
    step();
    check("en0_hold2", q, 4'b1110);

    // tc still reported while disabled
    en   = 1'b1;
    mode = 2'b11;
    d    = 4'b0000;
    step();
    en   = 1'b0;
    mode = 2'b10;
    d    = 4'b1111;
    step();
    check("en0_dn_hold", q,          4'b0000);
    check("en0_tc",      {3'b0, tc}, 4'b0001);
    mode = 2'b11;   // load blocked by en=0
    step();
    check("en0_ld_blocked", q, 4'b0000);

    // ---------------- Reset mid-count ----------------
    en   = 1'b1;
    mode = 2'b11;
    d    = 4'b0101;
    step();
    check("ld_0101", q, 4'b0101);
    mode = 2'b01;
    step();
    check("mid_up_0110", q, 4'b0110);
    rst_n = 1'b0;
    step();
    check("mid_rst", q, 4'b1010);
    rst_n = 1'b1;
    step();
    check("mid_resume", q, 4'b1011);

    // ---------------- Randomised invariant / model phase ----------------
    rst_n = 1'b0;
    step();
    m_q   = RV;
    rst_n = 1'b1;
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom_range(0, 3));
      j     = 4'($urandom);
      k     = 4'($urandom);
      d     = 4'($urandom);
      #1;
      m_tc = 4'b0000;
      if (mode == 2'b01 && m_q == 4'b1111) m_tc = 4'b0001;
      if (mode == 2'b10 && m_q == 4'b0000) m_tc = 4'b0001;
      check("rnd_tc", {3'b0, tc}, m_tc);
      if (!rst_n)          m_q = RV;
      else if (en) begin
        case (mode)
          2'b00:   m_q = (j & ~m_q) | (~k & m_q);
          2'b01:   m_q = m_q + 4'd1;
          2'b10:   m_q = m_q - 4'd1;
          default: m_q = d;
        endcase
      end
      step();
      check("rnd_q",    q,    m_q);
      check("rnd_qbar", qbar, ~q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog in case the clock or a step ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_jk_reg_bank
`default_nettype wire
